// File: rtl/ram_bist_ctrl.sv
// March-free write-then-read self-test sequencer for a single-port RAM.
// Optional build macro: BIST_STOP_ON_ERR_EN (abort to DONE on the first mismatch).
module ram_bist_ctrl #(
  parameter int AW     = 3,
  parameter int DW     = 4,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1,
  parameter int SEED   = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_invert,
  input  logic [DW-1:0]              i_read_data,
  output logic                       o_write_en,
  output logic [AW-1:0]              o_addr,
  output logic [DW-1:0]              o_write_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_pass,
  output logic [$clog2(DEPTH+1)-1:0] o_err_count,
  output logic [AW-1:0]              o_first_err_addr
);

  localparam int EW = $clog2(DEPTH + 1);
  // One extra bit so DEPTH = 2^AW ends on a terminal count instead of wrapping.
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] WR_LAST   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH + RD_LAT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(DEPTH);
  localparam logic [DW-1:0] SEED_W    = DW'(SEED);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            inv_q;
  logic [EW-1:0]   err_q;
  logic [AW-1:0]   first_q;
  logic            pass_q;

  logic [AW-1:0]   cnt_addr;
  logic [AW-1:0]   rd_addr;
  logic            rd_issue;
  logic            cmp_valid;
  logic [AW-1:0]   cmp_addr;
  logic [DW-1:0]   cmp_exp;
  logic            mismatch;
  logic [EW-1:0]   err_inc;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic inv);
    logic [DW-1:0] p;
    p = DW'(a) + SEED_W;
    return inv ? ~p : p;
  endfunction

  assign cnt_addr = cnt_q[AW-1:0];
  // After the last address the read port parks on DEPTH-1 while the pipeline drains.
  assign rd_addr  = (cnt_q < DEPTH_C) ? cnt_addr : LAST_ADDR;
  assign rd_issue = (state_q == S_RD) && (cnt_q < DEPTH_C);

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_valid = rd_issue;
      assign cmp_addr  = rd_addr;
      assign cmp_exp   = pat(rd_addr, inv_q);
    end else begin : g_lat1
      logic          pv_q;
      logic [AW-1:0] pa_q;
      logic [DW-1:0] pe_q;

      // NOTE: pipeline registers are few and cheap, so they are cleared on reset to keep
      // a stale valid from scoring a compare after an aborted test.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          pv_q <= 1'b0;
          pa_q <= '0;
          pe_q <= '0;
        end else begin
          pv_q <= rd_issue;
          pa_q <= rd_addr;
          pe_q <= pat(rd_addr, inv_q);
        end
      end

      assign cmp_valid = pv_q;
      assign cmp_addr  = pa_q;
      assign cmp_exp   = pe_q;
    end
  endgenerate

  assign mismatch = cmp_valid && (state_q == S_RD) && (i_read_data != cmp_exp);
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + EW'(1);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    o_write_en   = 1'b0;
    o_addr       = '0;
    o_write_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_WR;
      end
      S_WR: begin
        o_write_en   = 1'b1;
        o_addr       = cnt_addr;
        o_write_data = pat(cnt_addr, inv_q);
        if (cnt_q == WR_LAST) state_d = S_RD;
      end
      S_RD: begin
        o_addr = rd_addr;
`ifdef BIST_STOP_ON_ERR_EN
        if (mismatch || (cnt_q == RD_LAST)) state_d = S_DONE;
`else
        if (cnt_q == RD_LAST) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all registers sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cnt_q   <= '0;
            inv_q   <= i_invert;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
          end
        end
        S_WR: begin
          cnt_q <= (cnt_q == WR_LAST) ? '0 : cnt_q + CW'(1);
        end
        S_RD: begin
          cnt_q <= cnt_q + CW'(1);
          if (mismatch) begin
            err_q <= err_inc;
            if (err_q == '0) first_q <= cmp_addr;
          end
          // The verdict folds in the compare happening on this same edge.
          if (state_d == S_DONE) pass_q <= (err_q == '0) && !mismatch;
        end
        S_DONE: begin
          cnt_q <= '0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = (state_q == S_DONE);
  assign o_pass           = pass_q;
  assign o_err_count      = err_q;
  assign o_first_err_addr = first_q;

endmodule
